instr_fetch_ctrl: RTL

//  Fetch sequencer for the instruction ROM. Owns the PC register, drives the ROM address

---
 rtl/fetch_pkg.sv | 12 +
 rtl/fetch_next_pc.sv | 32 +++
 rtl/instr_fetch_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch definitions: sequencer states, next-PC selector and the HALT opcode
// that the decoder also uses.
package fetch_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} fetch_state_t;

  typedef enum logic [1:0] {PC_HOLD, PC_INC, PC_REDIR, PC_START} pc_sel_t;

  localparam int FETCH_OPC_W = 6;
  localparam logic [FETCH_OPC_W-1:0] HALT_OPCODE = '1;

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC mux for the fetch sequencer: hold, increment (with optional wrap), redirect
// or start, plus an end-of-memory flag for the current PC.
module fetch_next_pc
  import fetch_pkg::*;
#(
  parameter int PC_WIDTH = 5,
  parameter int WRAP_EN  = 0
) (
  input  pc_sel_t             sel,
  input  logic [PC_WIDTH-1:0] pc,
  input  logic [PC_WIDTH-1:0] start_pc,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic [PC_WIDTH-1:0] pc_next,
  output logic                at_end
);

  always_comb begin
    at_end  = &pc;
    pc_next = pc;
    case (sel)
      PC_INC: begin
        // Without wrap the PC parks on the last address instead of rolling to 0.
        if (at_end && (WRAP_EN == 0)) pc_next = pc;
        else                          pc_next = pc + 1'b1;
      end
      PC_REDIR: pc_next = redirect_pc;
      PC_START: pc_next = start_pc;
      default:  pc_next = pc;
    endcase
  end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, drives the ROM address and registers the
// fetched word into a valid/ready output slot towards the decoder.
module instr_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int PC_WIDTH    = 5,
  parameter int INSTR_WIDTH = 59,
  parameter int OPC_W       = 6,
  parameter int WRAP_EN     = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [PC_WIDTH-1:0]    start_pc,
  input  logic                   redirect_valid,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  input  logic                   halt_req,
  output logic [PC_WIDTH-1:0]    pc_address,
  input  logic [INSTR_WIDTH-1:0] instr_in,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic [PC_WIDTH-1:0]    instr_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic                   busy,
  output logic                   done
);

  localparam logic [OPC_W-1:0] HALT_OPC = {OPC_W{1'b1}};

  fetch_state_t           state_reg, state_next;
  logic [PC_WIDTH-1:0]    pc_reg, pc_next;
  logic [INSTR_WIDTH-1:0] instr_out_reg;
  logic [PC_WIDTH-1:0]    instr_pc_reg;
  logic                   instr_valid_reg, valid_next;
  logic                   done_reg, done_next;
  logic                   load;
  logic                   at_end;
  logic                   xfer;
  logic                   is_halt;
  pc_sel_t                pc_sel;

  assign xfer    = instr_valid_reg & instr_ready;
  assign is_halt = (instr_in[INSTR_WIDTH-1 -: OPC_W] == HALT_OPC);

  fetch_next_pc #(
    .PC_WIDTH (PC_WIDTH),
    .WRAP_EN  (WRAP_EN)
  ) u_next_pc (
    .sel         (pc_sel),
    .pc          (pc_reg),
    .start_pc    (start_pc),
    .redirect_pc (redirect_pc),
    .pc_next     (pc_next),
    .at_end      (at_end)
  );

  always_comb begin
    state_next = state_reg;
    pc_sel     = PC_HOLD;
    load       = 1'b0;
    // An accepted word frees the slot unless something below refills it.
    valid_next = instr_valid_reg & ~xfer;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          pc_sel     = PC_START;
        end
      end
      RUN: begin
        if (halt_req) begin
          state_next = DRAIN;
        end else if (redirect_valid) begin
          pc_sel     = PC_REDIR;
          valid_next = 1'b0;
        end else if (!instr_valid_reg || instr_ready) begin
          load       = 1'b1;
          pc_sel     = PC_INC;
          valid_next = 1'b1;
          if (is_halt || (at_end && (WRAP_EN == 0))) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (!instr_valid_reg || xfer) begin
          state_next = IDLE;
          valid_next = 1'b0;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      pc_reg          <= '0;
      instr_out_reg   <= '0;
      instr_pc_reg    <= '0;
      instr_valid_reg <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      instr_valid_reg <= valid_next;
      done_reg        <= done_next;
      if (load) begin
        instr_out_reg <= instr_in;
        instr_pc_reg  <= pc_reg;
      end
    end
  end

  assign pc_address  = pc_reg;
  assign instr_out   = instr_out_reg;
  assign instr_pc    = instr_pc_reg;
  assign instr_valid = instr_valid_reg;
  assign busy        = (state_reg != IDLE);
  assign done        = done_reg;

endmodule
